data_mem_responder: RTL and testbench

- Memory-side responder for the CPU's data-memory port: accepts one load/store request at a time over a valid/ready request channel and returns data or error over a valid/ready response channel.
- Inserts a programmable number of wait states, so the multi-cycle CPU variants can be exercised against realistic memory latency.
- Checks alignment and address range. Owns a word-addressed storage array.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 40 ++++
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory responder slice.
//   - state_t      : responder FSM encoding (IDLE / WAIT / RESP)
//   - WAIT_W       : width of the wait-state counter (covers 0..15)
//   - BYTE_OFF_BITS: byte-offset bits inside a 32-bit word
// ----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WAIT_W        = 4;
    localparam int BYTE_OFF_BITS = 2;

endpackage

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
//   Single-port synchronous RAM, DEPTH x 32 bits. On an enabled edge either
//   the addressed word is written (we=1) or it is read into the rdata
//   register (we=0). rdata holds its value between enabled reads.
//   Contents and rdata are not reset.
//
//   Ports:
//     clock  in   rising-edge clock
//     en     in   access enable for this edge
//     we     in   1 = write, 0 = read
//     addr   in   word index
//     wdata  in   write data
//     rdata  out  registered read data
// ----------------------------------------------------------------------------
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the CPU data port. Accepts one load/store at a
//   time, waits WAIT_CYCLES states, performs the access on dmem_array with
//   alignment and range checking, then presents the response until taken.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both 1. req_ready is 1 only in IDLE; rsp_valid is 1 only in RESP and
//   rsp_rdata/rsp_err stay constant until the response is taken.
//
//   Ports:
//     clock      in   system clock
//     reset      in   asynchronous active-low reset
//     req_valid  in   request present
//     req_ready  out  responder can accept a request
//     req_we     in   1 = store, 0 = load
//     req_addr   in   byte address
//     req_wdata  in   store data
//     rsp_valid  out  response present
//     rsp_ready  in   CPU accepts the response
//     rsp_rdata  out  load data (0 for stores and errors)
//     rsp_err    out  misaligned or out-of-range access
// ----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WAIT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);
    // Byte size of the window, one bit wider so DEPTH*4 never overflows.
    localparam logic [32:0] LIMIT = 33'(DEPTH) << BYTE_OFF_BITS;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic              err_q;
    logic              load_q;    // response carries array read data

    logic              accept;
    logic              acc_fire;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [31:0]       acc_off;
    logic              acc_err;
    logic [31:0]       ram_rdata;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // With zero wait states the access happens on the acceptance edge itself,
    // so the live request fields feed the array instead of the latched copy.
    assign acc_fire = (accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == '0));
    assign acc_we    = (state_q == ST_IDLE) ? req_we    : lat_we;
    assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : lat_wdata;

    assign acc_off = acc_addr - BASE_ADDR;
    assign acc_err = (acc_addr[BYTE_OFF_BITS-1:0] != '0) ||
                     (acc_addr < BASE_ADDR) ||
                     ({1'b0, acc_off} >= LIMIT);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock (clock),
        .en    (acc_fire && !acc_err),
        .we    (acc_we),
        .addr  (acc_off[AW+BYTE_OFF_BITS-1:BYTE_OFF_BITS]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // State register, wait counter, request latch and response flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            err_q     <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt_q     <= CNT_INIT;
            end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (acc_fire) begin
                err_q  <= acc_err;
                load_q <= !acc_err && !acc_we;
            end else if ((state_q == ST_RESP) && rsp_ready) begin
                err_q  <= 1'b0;
                load_q <= 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. The array's read register is stable throughout RESP because
    // no other access can start until the response is taken.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = (state_q == ST_RESP) && err_q;
        rsp_rdata = ((state_q == ST_RESP) && load_q) ? ram_rdata : 32'h0;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//   Two responder instances: index 0 (WAIT_CYCLES=2, BASE=0) and index 1
//   (WAIT_CYCLES=0, BASE=0x1000_0000), both DEPTH=256. Each has a behavioural
//   model (age since acceptance plus a sparse word map) compared against the
//   DUT on every falling edge, plus directed literal checks.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic        clock;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUTs, models and compare processes ----------------
    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int          WC   = (g == 0) ? 2 : 0;
        localparam logic [31:0] BASE = (g == 0) ? 32'h0 : 32'h1000_0000;

        data_mem_responder #(
            .DEPTH       (DEPTH),
            .WAIT_CYCLES (WC),
            .BASE_ADDR   (BASE)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );

        logic        m_busy  = 1'b0;
        int          m_age   = 0;
        logic        m_we;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic        m_err   = 1'b0;
        logic [31:0] m_data  = '0;
        logic        m_known = 1'b1;
        logic [31:0] m_mem [int];

        always @(posedge clock or negedge reset) begin : model
            logic   acc;
            longint off;
            acc = 1'b0;
            if (!reset) begin
                m_busy = 1'b0;
                m_age  = 0;
            end else if (!m_busy) begin
                if (req_valid[g]) begin
                    m_busy  = 1'b1;
                    m_age   = 0;
                    m_we    = req_we[g];
                    m_addr  = req_addr[g];
                    m_wdata = req_wdata[g];
                    acc     = (WC == 0);
                end
            end else if (m_age < WC) begin
                m_age++;
                acc = (m_age == WC);
            end else if (rsp_ready[g]) begin
                m_busy = 1'b0;
            end
            if (acc) begin
                off     = longint'(m_addr) - longint'(BASE);
                m_err   = (m_addr[1:0] != 2'b00) || (off < 0) || (off >= longint'(DEPTH) * 4);
                m_data  = '0;
                m_known = 1'b1;
                if (!m_err) begin
                    if (m_we) begin
                        m_mem[int'(off / 4)] = m_wdata;
                    end else if (m_mem.exists(int'(off / 4))) begin
                        m_data = m_mem[int'(off / 4)];
                    end else begin
                        m_known = 1'b0;
                    end
                end
            end
        end

        always @(negedge clock) begin : compare
            logic exp_valid;
            exp_valid = m_busy && (m_age >= WC);
            check($sformatf("cfg%0d req_ready", g), 32'(req_ready[g]), 32'(!m_busy));
            check($sformatf("cfg%0d rsp_valid", g), 32'(rsp_valid[g]), 32'(exp_valid));
            check($sformatf("cfg%0d rsp_err", g), 32'(rsp_err[g]), 32'(exp_valid && m_err));
            if (!exp_valid || m_known) begin
                check($sformatf("cfg%0d rsp_rdata", g), rsp_rdata[g], exp_valid ? m_data : 32'h0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic junk(input int i);
        req_valid[i] = 1'($urandom_range(0, 1));
        req_we[i]    = 1'($urandom_range(0, 1));
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
    endtask

    // One complete transaction starting from IDLE. hold=0 keeps rsp_ready
    // high throughout; otherwise rsp_ready stays low for hold cycles of RESP.
    task automatic txn(input int i, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clock);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        rsp_ready[i] = (hold == 0);
        @(negedge clock);
        lat = 1;
        while (!rsp_valid[i] && lat < 40) begin
            junk(i);
            @(negedge clock);
            lat++;
        end
        if (!rsp_valid[i]) check("rsp_valid timeout", 32'(rsp_valid[i]), 32'h1);
        rdata = rsp_rdata[i];
        err   = rsp_err[i];
        if (hold > 0) begin
            repeat (hold) begin
                junk(i);
                @(negedge clock);
            end
        end
        req_valid[i] = 1'b0;
        rsp_ready[i] = 1'b1;
        @(negedge clock);
        rsp_ready[i] = 1'b0;
    endtask

    task automatic random_phase(input int i, input logic [31:0] base, input int n);
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          r;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            a = base + 32'($urandom_range(0, 15)) * 4;
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            else if (r == 1) a = base + 32'h400 + 32'($urandom_range(0, 15)) * 4;
            else if (r == 2) a = base - 32'($urandom_range(1, 8)) * 4;
            txn(i, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), rd, er, lt);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] rd;
        logic        er;
        int          lt;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset req_ready", 32'(req_ready[i]), 32'h1);
            check("reset rsp_valid", 32'(rsp_valid[i]), 32'h0);
            check("reset rsp_rdata", rsp_rdata[i], 32'h0);
            check("reset rsp_err", 32'(rsp_err[i]), 32'h0);
        end
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;

        // Instance 0: WAIT_CYCLES=2, BASE=0
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lt);
        check("store latency", 32'(lt), 32'd3);
        check("store err", 32'(er), 32'h0);
        check("store rdata", rd, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, rd, er, lt);
        check("load 0x10 data", rd, 32'hDEAD_BEEF);
        check("load latency", 32'(lt), 32'd3);

        txn(0, 1'b0, 32'h12, 32'h0, 0, rd, er, lt);
        check("misaligned err", 32'(er), 32'h1);
        check("misaligned rdata", rd, 32'h0);
        txn(0, 1'b1, 32'h3FC, 32'hCAFE_0001, 0, rd, er, lt);
        txn(0, 1'b1, 32'h400, 32'hBAD0_BAD0, 0, rd, er, lt);
        check("range err", 32'(er), 32'h1);
        check("range rdata", rd, 32'h0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 0, rd, er, lt);
        check("0x3FC unchanged", rd, 32'hCAFE_0001);

        // rsp_ready low for 5 cycles of RESP with junk on the request side
        txn(0, 1'b0, 32'h10, 32'h0, 5, rd, er, lt);
        check("held load data", rd, 32'hDEAD_BEEF);

        // reset during WAIT of a store
        txn(0, 1'b1, 32'h20, 32'hA5A5_A5A5, 0, rd, er, lt);
        @(negedge clock);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h1234_5678;
        @(negedge clock);
        req_valid[0] = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("mid-wait reset req_ready", 32'(req_ready[0]), 32'h1);
        check("mid-wait reset rsp_valid", 32'(rsp_valid[0]), 32'h0);
        #1 reset = 1'b1;
        repeat (4) @(negedge clock);
        txn(0, 1'b0, 32'h20, 32'h0, 0, rd, er, lt);
        check("0x20 after reset", rd, 32'hA5A5_A5A5);

        // Instance 1: WAIT_CYCLES=0, BASE=0x1000_0000
        txn(1, 1'b1, 32'h1000_0004, 32'd7, 0, rd, er, lt);
        check("wc0 store latency", 32'(lt), 32'd1);
        txn(1, 1'b0, 32'h1000_0004, 32'h0, 0, rd, er, lt);
        check("wc0 load data", rd, 32'd7);
        check("wc0 load latency", 32'(lt), 32'd1);
        txn(1, 1'b0, 32'h0FFF_FFFC, 32'h0, 0, rd, er, lt);
        check("below base err", 32'(er), 32'h1);

        random_phase(0, 32'h0, 60);
        random_phase(1, 32'h1000_0000, 60);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
